multi_mode_ff_reg: RTL and testbench

- Parametrised WIDTH-bit register bank; every bit is a flip-flop whose type (D, T, JK, SR) is selected at run time by a mode input.
- Adds hold, load-enable and serial shift modes for bit-slice storage, counters and shift chains.
- Generalises the single-bit, fixed-type flip-flop cells in the flip-flop library into one configurable block.
- Sits in the FLIP_FLOPS library as the common storage primitive for higher-level blocks.

---
 rtl/multi_mode_ff_reg.sv | 176 +++++++++++++++++
 tb/tb_multi_mode_ff_reg.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_mode_ff_reg.sv
// ----------------------------------------------------------------------------
// multi_mode_ff_reg
//   WIDTH-bit register bank in which every bit behaves as a D, T, JK or SR
//   flip-flop, selected at run time by `mode`. It also supports hold and
//   serial shift left/right, so it can be used for bit-slice storage,
//   counters and shift chains.
//
// Parameters
//   WIDTH        number of bits, 1..64
//   RESET_VAL    reset value of q (only the low WIDTH bits are used)
//   SR_PRIORITY  how SR mode resolves S=R=1: 0 hold, 1 set wins, 2 reset wins
//
// Ports
//   clk     in   rising-edge clock
//   reset   in   asynchronous active-high reset
//   en      in   clock enable; q holds when low
//   mode    in   [2:0]  0 HOLD,1 D,2 T,3 JK,4 SR,5 SHL,6 SHR,7 HOLD
//   a       in   [WIDTH] d / t / j / s
//   b       in   [WIDTH] k / r
//   sin     in   serial input for the shift modes
//   q       out  [WIDTH] register state
//   qb      out  [WIDTH] ~q
//   sout    out  q[WIDTH-1] in SHL, q[0] in SHR, otherwise 0
//   sr_err  out  sticky flag: S=R=1 was seen on an enabled SR edge
//                (present only when MULTI_MODE_FF_SR_ERR_EN is defined)
//
// Optional feature macro: MULTI_MODE_FF_SR_ERR_EN
// ----------------------------------------------------------------------------

// Per-bit next-state cell. It is purely combinational; the top level holds
// the register.
module multi_mode_ff_bit #(
  parameter int SR_PRIORITY = 0
) (
  input  logic [2:0] mode_i,
  input  logic       q_i,
  input  logic       a_i,
  input  logic       b_i,
  input  logic       shl_i,   // value shifted into this bit in SHL
  input  logic       shr_i,   // value shifted into this bit in SHR
  output logic       d_o
);
  localparam logic [2:0] M_HOLD = 3'd0;
  localparam logic [2:0] M_D    = 3'd1;
  localparam logic [2:0] M_T    = 3'd2;
  localparam logic [2:0] M_JK   = 3'd3;
  localparam logic [2:0] M_SR   = 3'd4;
  localparam logic [2:0] M_SHL  = 3'd5;
  localparam logic [2:0] M_SHR  = 3'd6;

  logic sr_both;

  // Resolve S=R=1 at elaboration time.
  always_comb begin
    sr_both = q_i;
    if (SR_PRIORITY == 1)      sr_both = 1'b1;
    else if (SR_PRIORITY == 2) sr_both = 1'b0;
  end

  always_comb begin
    d_o = q_i;
    case (mode_i)
      M_HOLD: d_o = q_i;
      M_D:    d_o = a_i;
      M_T:    d_o = q_i ^ a_i;
      M_JK: begin
        case ({a_i, b_i})
          2'b01:   d_o = 1'b0;
          2'b10:   d_o = 1'b1;
          2'b11:   d_o = ~q_i;
          default: d_o = q_i;
        endcase
      end
      M_SR: begin
        case ({a_i, b_i})
          2'b01:   d_o = 1'b0;
          2'b10:   d_o = 1'b1;
          2'b11:   d_o = sr_both;
          default: d_o = q_i;
        endcase
      end
      M_SHL:   d_o = shl_i;
      M_SHR:   d_o = shr_i;
      default: d_o = q_i;   // 3'd7 is reserved and behaves as HOLD
    endcase
  end
endmodule

module multi_mode_ff_reg #(
  parameter int          WIDTH       = 8,
  parameter logic [63:0] RESET_VAL   = 64'd0,
  parameter int          SR_PRIORITY = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             sout
`ifdef MULTI_MODE_FF_SR_ERR_EN
  ,
  output logic             sr_err
`endif
);
  localparam logic [WIDTH-1:0] RST_Q = RESET_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] shl_src;
  logic [WIDTH-1:0] shr_src;

  // Shift neighbours. The end bits take sin, so for WIDTH=1 both shift
  // modes reduce to q <= sin.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i == 0) begin : g_shl_end
      assign shl_src[i] = sin;
    end else begin : g_shl_mid
      assign shl_src[i] = q_q[i-1];
    end
    if (i == WIDTH-1) begin : g_shr_end
      assign shr_src[i] = sin;
    end else begin : g_shr_mid
      assign shr_src[i] = q_q[i+1];
    end

    multi_mode_ff_bit #(
      .SR_PRIORITY (SR_PRIORITY)
    ) u_bit (
      .mode_i (mode),
      .q_i    (q_q[i]),
      .a_i    (a[i]),
      .b_i    (b[i]),
      .shl_i  (shl_src[i]),
      .shr_i  (shr_src[i]),
      .d_o    (q_d[i])
    );
  end

  // Any pending next state is dropped when reset arrives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   q_q <= RST_Q;
    else if (en) q_q <= q_d;
  end

  assign q  = q_q;
  assign qb = ~q_q;

  always_comb begin
    sout = 1'b0;
    if (mode == 3'd5)      sout = q_q[WIDTH-1];
    else if (mode == 3'd6) sout = q_q[0];
  end

`ifdef MULTI_MODE_FF_SR_ERR_EN
  logic sr_err_q;
  logic sr_err_d;

  // The flag is sticky and does not depend on SR_PRIORITY. It is set on the
  // same edge that q takes its SR update.
  always_comb begin
    sr_err_d = sr_err_q;
    if (en && (mode == 3'd4) && |(a & b)) sr_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sr_err_q <= 1'b0;
    else       sr_err_q <= sr_err_d;
  end

  assign sr_err = sr_err_q;
`endif
endmodule

// File: tb/tb_multi_mode_ff_reg.sv
module tb_multi_mode_ff_reg;
  localparam logic [7:0] RV = 8'hA5;

  logic       clk = 1'b0;
  logic       reset, en, sin;
  logic [2:0] mode;
  logic [7:0] a, b;

  logic [7:0] q0, q1, q2, qb0, qb1, qb2;
  logic       so0, so1, so2;
  logic [0:0] qw, qbw;
  logic       sow;
`ifdef MULTI_MODE_FF_SR_ERR_EN
  logic       e0, e1, e2, ew;
`endif

  always #5 clk = ~clk;

  multi_mode_ff_reg #(.WIDTH(8), .RESET_VAL(64'(RV)), .SR_PRIORITY(0)) dut0 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .a(a), .b(b), .sin(sin),
    .q(q0), .qb(qb0), .sout(so0)
`ifdef MULTI_MODE_FF_SR_ERR_EN
    , .sr_err(e0)
`endif
  );
  multi_mode_ff_reg #(.WIDTH(8), .RESET_VAL(64'(RV)), .SR_PRIORITY(1)) dut1 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .a(a), .b(b), .sin(sin),
    .q(q1), .qb(qb1), .sout(so1)
`ifdef MULTI_MODE_FF_SR_ERR_EN
    , .sr_err(e1)
`endif
  );
  multi_mode_ff_reg #(.WIDTH(8), .RESET_VAL(64'(RV)), .SR_PRIORITY(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .a(a), .b(b), .sin(sin),
    .q(q2), .qb(qb2), .sout(so2)
`ifdef MULTI_MODE_FF_SR_ERR_EN
    , .sr_err(e2)
`endif
  );
  multi_mode_ff_reg #(.WIDTH(1), .RESET_VAL(64'(RV)), .SR_PRIORITY(1)) dutw (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .a(a[0:0]), .b(b[0:0]),
    .sin(sin), .q(qw), .qb(qbw), .sout(sow)
`ifdef MULTI_MODE_FF_SR_ERR_EN
    , .sr_err(ew)
`endif
  );

  // Reference state: one word per SR_PRIORITY, plus the 1-bit instance.
  logic [63:0] m [3];
  logic [63:0] mw;
  logic        merr, merr_w;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Word-level model derived from the mode rules.
  function automatic logic [63:0] ref_next(input int w, input int pri, input logic [63:0] q,
                                           input logic [2:0] md, input logic [63:0] ai,
                                           input logic [63:0] bi, input logic s);
    logic [63:0] mask, n, set1, clr1, both;
    mask = (64'd1 << w) - 64'd1;
    set1 = ai & ~bi;
    clr1 = ~ai & bi;
    both = ai & bi;
    case (md)
      3'd1: n = ai;
      3'd2: n = q ^ ai;
      3'd3: n = (ai & ~q) | (~bi & q);
      3'd4: begin
        n = set1 | (q & ~clr1);
        if (pri == 1) n = n | both;
        if (pri == 2) n = n & ~both;
      end
      3'd5: n = (q << 1) | 64'(s);
      3'd6: n = (q >> 1) | (64'(s) << (w - 1));
      default: n = q;
    endcase
    return n & mask;
  endfunction

  function automatic logic ref_sout(input int w, input logic [63:0] q, input logic [2:0] md);
    if (md == 3'd5) return q[w-1];
    if (md == 3'd6) return q[0];
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) m[k] = 64'(RV);
    mw = 64'(RV[0]);
    merr = 1'b0;
    merr_w = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".q0"},  64'(q0),  m[0]);
    chk({tag, ".q1"},  64'(q1),  m[1]);
    chk({tag, ".q2"},  64'(q2),  m[2]);
    chk({tag, ".qb0"}, 64'(qb0), ~m[0] & 64'hFF);
    chk({tag, ".qb2"}, 64'(qb2), ~m[2] & 64'hFF);
    chk({tag, ".so0"}, 64'(so0), 64'(ref_sout(8, m[0], mode)));
    chk({tag, ".qw"},  64'(qw),  mw);
    chk({tag, ".qbw"}, 64'(qbw), ~mw & 64'h1);
    chk({tag, ".sow"}, 64'(sow), 64'(ref_sout(1, mw, mode)));
`ifdef MULTI_MODE_FF_SR_ERR_EN
    chk({tag, ".err0"}, 64'(e0), 64'(merr));
    chk({tag, ".err1"}, 64'(e1), 64'(merr));
    chk({tag, ".err2"}, 64'(e2), 64'(merr));
    chk({tag, ".errw"}, 64'(ew), 64'(merr_w));
`endif
  endtask

  // Advance one rising edge with the current inputs and check the result.
  task automatic cycle(input string tag);
    logic [63:0] nm [3];
    logic [63:0] nw;
    for (int k = 0; k < 3; k++)
      nm[k] = en ? ref_next(8, k, m[k], mode, 64'(a), 64'(b), sin) : m[k];
    nw = en ? ref_next(1, 1, mw, mode, 64'(a[0]), 64'(b[0]), sin) : mw;
    if (en && mode == 3'd4 && |(a & b)) merr = 1'b1;
    if (en && mode == 3'd4 && (a[0] & b[0])) merr_w = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 3; k++) m[k] = nm[k];
    mw = nw;
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic [2:0] md, input logic [7:0] ai, input logic [7:0] bi,
                       input logic s, input logic e);
    mode = md; a = ai; b = bi; sin = s; en = e;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; mode = 3'd0; a = '0; b = '0; sin = 1'b0;
    model_reset();
    #2;
    check_all("rst_init");
    chk("rst_q_A5", 64'(q0), 64'hA5);
    chk("rst_qb_5A", 64'(qb0), 64'h5A);

    // Edges while reset is held are ignored.
    drive(3'd1, 8'hFF, 8'h00, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_q", 64'(q0), 64'hA5);
    @(negedge clk);
    reset = 1'b0;

    // D with enable.
    drive(3'd1, 8'h3C, 8'h00, 1'b0, 1'b1);
    cycle("d_load");
    chk("d_3C", 64'(q0), 64'h3C);
    drive(3'd1, 8'hFF, 8'h00, 1'b0, 1'b0);
    repeat (3) cycle("en_off");
    chk("en_hold_3C", 64'(q0), 64'h3C);

    // T then JK.
    drive(3'd1, 8'h0F, 8'h00, 1'b0, 1'b1); cycle("pre_t");
    drive(3'd2, 8'hFF, 8'h00, 1'b0, 1'b1); cycle("t");
    chk("t_F0", 64'(q0), 64'hF0);
    drive(3'd3, 8'hC0, 8'h30, 1'b0, 1'b1); cycle("jk");
    chk("jk_C0", 64'(q0), 64'hC0);

    // SR with S=R=1 on bit 0.
    drive(3'd1, 8'h00, 8'h00, 1'b0, 1'b1); cycle("pre_sr");
    drive(3'd4, 8'h01, 8'h01, 1'b0, 1'b1); cycle("sr");
    chk("sr_pri0", 64'(q0), 64'h00);
    chk("sr_pri1", 64'(q1), 64'h01);
    chk("sr_pri2", 64'(q2), 64'h00);
    drive(3'd0, 8'h00, 8'h00, 1'b0, 1'b1); cycle("sr_sticky");

    // Shifts.
    drive(3'd1, 8'h81, 8'h00, 1'b0, 1'b1); cycle("pre_shl");
    drive(3'd5, 8'h00, 8'h00, 1'b0, 1'b1);
    #1;
    chk("shl_sout_pre", 64'(so0), 64'h1);
    cycle("shl");
    chk("shl_02", 64'(q0), 64'h02);
    drive(3'd6, 8'h00, 8'h00, 1'b1, 1'b1); cycle("shr");
    chk("shr_81", 64'(q0), 64'h81);

    // Reserved mode holds.
    drive(3'd7, 8'hFF, 8'hFF, 1'b1, 1'b1);
    repeat (2) cycle("rsvd");
    chk("rsvd_81", 64'(q0), 64'h81);

    // Reset asserted just before an edge with a pending D load.
    drive(3'd1, 8'h55, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("midrst_now");
    @(posedge clk);
    #1;
    chk("midrst_after_edge", 64'(q0), 64'hA5);
    check_all("midrst_edge");
    @(negedge clk);
    reset = 1'b0;

    // Random traffic with occasional asynchronous reset pulses.
    for (int it = 0; it < 400; it++) begin
      drive(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom),
            ($urandom_range(0, 4) != 0));
      if ($urandom_range(0, 24) == 0) begin
        reset = 1'b1;
        model_reset();
        #1;
        check_all("rnd_rst");
        reset = 1'b0;
      end
      cycle("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
